hilo_pipe: RTL and testbench

Write-side counterpart of the execute stage's HI/LO request interface: accepts per-instruction HI/LO write requests (`ex_hi_i`/`ex_lo_i`/`ex_whilo_i`) and carries them through the EX/MEM and MEM/WB boundaries. It commits them to the architectural HI/LO registers at writeback. It returns the in-flight MEM and WB requests and the committed HI/LO values to the execute stage for forwarding, and it honours per-stage stall and a pipeline flush.

---
 rtl/hilo_pipe_if.sv | 37 +++
 rtl/hilo_pipe.sv | 105 ++++++++++
 tb/tb_hilo_pipe.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_pipe_if.sv
// HI/LO write-request bus between the execute stage and hilo_pipe.
// The execute stage uses the master side: it drives requests, stall and flush,
// and reads back the forwarding sources and the architectural HI/LO.
interface hilo_pipe_if;
    // Request side: the instruction currently in EX
    logic [31:0] ex_hi_i;
    logic [31:0] ex_lo_i;
    logic        ex_whilo_i;
    logic [2:0]  stall_i;
    logic        flush_i;

    // Forwarding sources and the architectural state
    logic [31:0] mem_hi_o;
    logic [31:0] mem_lo_o;
    logic        mem_whilo_o;
    logic [31:0] wb_hi_o;
    logic [31:0] wb_lo_o;
    logic        wb_whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        hilo_busy_o;
    logic [15:0] wcnt_o;

    modport master (
        output ex_hi_i, ex_lo_i, ex_whilo_i, stall_i, flush_i,
        input  mem_hi_o, mem_lo_o, mem_whilo_o,
        input  wb_hi_o, wb_lo_o, wb_whilo_o,
        input  hi_o, lo_o, hilo_busy_o, wcnt_o
    );

    modport slave (
        input  ex_hi_i, ex_lo_i, ex_whilo_i, stall_i, flush_i,
        output mem_hi_o, mem_lo_o, mem_whilo_o,
        output wb_hi_o, wb_lo_o, wb_whilo_o,
        output hi_o, lo_o, hilo_busy_o, wcnt_o
    );
endinterface

// File: rtl/hilo_pipe.sv
// HI/LO write pipeline: carries EX write requests through EX/MEM and MEM/WB,
// commits them to the architectural HI/LO at writeback and exposes every
// in-flight stage for forwarding back into EX.
module hilo_pipe (
    input  logic        clk,
    input  logic        rst,
    hilo_pipe_if.slave  bus
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic          whilo;
    } hilo_req_t;

    localparam hilo_req_t REQ_NONE = '0;

    hilo_req_t     ex_req_c;
    hilo_req_t     em_q, em_d;
    hilo_req_t     mw_q, mw_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          commit_c;

    // Pack the EX request; data travels even when whilo is low (don't-care)
    always_comb begin
        ex_req_c       = REQ_NONE;
        ex_req_c.hi    = bus.ex_hi_i;
        ex_req_c.lo    = bus.ex_lo_i;
        ex_req_c.whilo = bus.ex_whilo_i;
    end

    // EX/MEM next value: flush, then bubble when EX stalls into a moving MEM
    always_comb begin
        em_d = em_q;
        if (bus.flush_i) begin
            em_d = REQ_NONE;
        end else if (bus.stall_i[0] && !bus.stall_i[1]) begin
            em_d = REQ_NONE;
        end else if (!bus.stall_i[0]) begin
            em_d = ex_req_c;
        end
    end

    // MEM/WB next value: same rules one stage further down
    always_comb begin
        mw_d = mw_q;
        if (bus.flush_i) begin
            mw_d = REQ_NONE;
        end else if (bus.stall_i[1] && !bus.stall_i[2]) begin
            mw_d = REQ_NONE;
        end else if (!bus.stall_i[1]) begin
            mw_d = em_q;
        end
    end

    // Writeback commit; a flush does not block it since WB has already retired
    always_comb begin
        commit_c = mw_q.whilo && !bus.stall_i[2];
        hi_d     = hi_q;
        lo_d     = lo_q;
        wcnt_d   = wcnt_q;
        if (commit_c) begin
            hi_d = mw_q.hi;
            lo_d = mw_q.lo;
            if (wcnt_q != {CW{1'b1}}) begin
                wcnt_d = wcnt_q + CW'(1);
            end
        end
    end

    // State registers with synchronous reset; in-flight requests are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            em_q   <= REQ_NONE;
            mw_q   <= REQ_NONE;
            hi_q   <= '0;
            lo_q   <= '0;
            wcnt_q <= '0;
        end else begin
            em_q   <= em_d;
            mw_q   <= mw_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            wcnt_q <= wcnt_d;
        end
    end

    // Outputs straight from registers; busy is the only OR of two flops
    assign bus.mem_hi_o    = em_q.hi;
    assign bus.mem_lo_o    = em_q.lo;
    assign bus.mem_whilo_o = em_q.whilo;
    assign bus.wb_hi_o     = mw_q.hi;
    assign bus.wb_lo_o     = mw_q.lo;
    assign bus.wb_whilo_o  = mw_q.whilo;
    assign bus.hi_o        = hi_q;
    assign bus.lo_o        = lo_q;
    assign bus.hilo_busy_o = em_q.whilo | mw_q.whilo;
    assign bus.wcnt_o      = wcnt_q;

endmodule

// File: tb/tb_hilo_pipe.sv
// Bench for hilo_pipe: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a stage-list model.
module tb_hilo_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_whilo;
    logic [2:0]  stall;
    logic        flush;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    hilo_pipe_if bus ();

    assign bus.ex_hi_i    = ex_hi;
    assign bus.ex_lo_i    = ex_lo;
    assign bus.ex_whilo_i = ex_whilo;
    assign bus.stall_i    = stall;
    assign bus.flush_i    = flush;

    hilo_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a list of pipeline slots, index 1 = EX/MEM, 2 = MEM/WB
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        w;
    } mreq_t;

    mreq_t       m_st [1:2];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: retire from the tail, then slots move forward, stage by stage
    always @(posedge clk) begin
        mreq_t src;
        if (rst) begin
            m_st[1] = '0;
            m_st[2] = '0;
            m_hi    = 32'h0;
            m_lo    = 32'h0;
            m_cnt   = 0;
        end else begin
            if (m_st[2].w && !stall[2]) begin
                m_hi = m_st[2].hi;
                m_lo = m_st[2].lo;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
            for (int k = 2; k >= 1; k--) begin
                if (k == 1) begin
                    src.hi = ex_hi;
                    src.lo = ex_lo;
                    src.w  = ex_whilo;
                end else begin
                    src = m_st[k-1];
                end
                if (flush)              m_st[k] = '0;
                else if (!stall[k-1])   m_st[k] = src;
                else if (!stall[k])     m_st[k] = '0;
            end
        end
    end

    // Per-cycle comparison against the model; data only checked when valid
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_whilo", 32'(bus.mem_whilo_o), 32'(m_st[1].w));
            chk("wb_whilo",  32'(bus.wb_whilo_o),  32'(m_st[2].w));
            chk("busy",      32'(bus.hilo_busy_o), 32'(m_st[1].w | m_st[2].w));
            if (m_st[1].w) begin
                chk("mem_hi", bus.mem_hi_o, m_st[1].hi);
                chk("mem_lo", bus.mem_lo_o, m_st[1].lo);
            end
            if (m_st[2].w) begin
                chk("wb_hi", bus.wb_hi_o, m_st[2].hi);
                chk("wb_lo", bus.wb_lo_o, m_st[2].lo);
            end
            chk("hi",   bus.hi_o, m_hi);
            chk("lo",   bus.lo_o, m_lo);
            chk("wcnt", 32'(bus.wcnt_o), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input logic w, input logic [31:0] h, input logic [31:0] l);
        ex_whilo = w;
        ex_hi    = h;
        ex_lo    = l;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 3'b000;
        flush = 1'b0;
        req(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state
        chk("rst_hi",   bus.hi_o, 32'h0);
        chk("rst_wcnt", 32'(bus.wcnt_o), 32'h0);
        chk("rst_busy", 32'(bus.hilo_busy_o), 32'h0);

        // Basic commit: three-cycle latency to architectural HI/LO
        req(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        tick();
        req(1'b0, 32'h0, 32'h0);
        chk("basic_mem_whilo", 32'(bus.mem_whilo_o), 32'h1);
        tick();
        chk("basic_wb_whilo", 32'(bus.wb_whilo_o), 32'h1);
        chk("basic_hi_early", bus.hi_o, 32'h0);
        tick();
        chk("basic_hi",   bus.hi_o, 32'h1234_5678);
        chk("basic_lo",   bus.lo_o, 32'h9ABC_DEF0);
        chk("basic_wcnt", 32'(bus.wcnt_o), 32'h1);

        // Back-to-back writes commit in order (wcnt is cumulative: 1 + 2)
        req(1'b1, 32'h1, 32'h2);
        tick();
        req(1'b1, 32'h3, 32'h4);
        tick();
        req(1'b0, 32'h0, 32'h0);
        tick();
        chk("b2b_hi_a", bus.hi_o, 32'h1);
        chk("b2b_lo_a", bus.lo_o, 32'h2);
        tick();
        chk("b2b_hi_b", bus.hi_o, 32'h3);
        chk("b2b_lo_b", bus.lo_o, 32'h4);
        chk("b2b_wcnt", 32'(bus.wcnt_o), 32'h3);

        // EX stall inserts bubbles, then exactly one commit
        stall = 3'b001;
        req(1'b1, 32'h5, 32'h55);
        tick();
        chk("exst_mem_whilo0", 32'(bus.mem_whilo_o), 32'h0);
        tick();
        chk("exst_mem_whilo1", 32'(bus.mem_whilo_o), 32'h0);
        stall = 3'b000;
        tick();
        req(1'b0, 32'h0, 32'h0);
        chk("exst_mem_hi", bus.mem_hi_o, 32'h5);
        tick();
        tick();
        chk("exst_hi",   bus.hi_o, 32'h5);
        chk("exst_wcnt", 32'(bus.wcnt_o), 32'h4);
        tick();
        chk("exst_wcnt_once", 32'(bus.wcnt_o), 32'h4);

        // WB stall holds the request visible and delays commit
        req(1'b1, 32'h9, 32'hA);
        tick();
        req(1'b0, 32'h0, 32'h0);
        tick();
        stall = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wbst_wb_whilo", 32'(bus.wb_whilo_o), 32'h1);
            chk("wbst_wb_hi",    bus.wb_hi_o, 32'h9);
            chk("wbst_hi_hold",  bus.hi_o, 32'h5);
        end
        stall = 3'b000;
        tick();
        chk("wbst_hi",   bus.hi_o, 32'h9);
        chk("wbst_wcnt", 32'(bus.wcnt_o), 32'h5);

        // Flush drops MEM (hi=7) but the WB write (hi=6) still commits
        req(1'b1, 32'h6, 32'h60);
        tick();
        req(1'b1, 32'h7, 32'h70);
        tick();
        req(1'b0, 32'h0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_hi",        bus.hi_o, 32'h6);
        chk("flush_mem_whilo", 32'(bus.mem_whilo_o), 32'h0);
        chk("flush_wb_whilo",  32'(bus.wb_whilo_o), 32'h0);
        tick();
        tick();
        chk("flush_hi_kept", bus.hi_o, 32'h6);
        chk("flush_wcnt",    32'(bus.wcnt_o), 32'h6);

        // Reset with two requests in flight
        req(1'b1, 32'h11, 32'h1);
        tick();
        req(1'b1, 32'h22, 32'h2);
        tick();
        req(1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_mem_whilo", 32'(bus.mem_whilo_o), 32'h0);
        chk("mrst_wb_whilo",  32'(bus.wb_whilo_o), 32'h0);
        chk("mrst_mem_hi",    bus.mem_hi_o, 32'h0);
        chk("mrst_wb_hi",     bus.wb_hi_o, 32'h0);
        chk("mrst_hi",        bus.hi_o, 32'h0);
        chk("mrst_lo",        bus.lo_o, 32'h0);
        chk("mrst_wcnt",      32'(bus.wcnt_o), 32'h0);

        // Random traffic with monotone stall vectors
        for (int n = 0; n < 3000; n++) begin
            int r;
            req(1'($urandom_range(0, 1)), $urandom, $urandom);
            r = int'($urandom_range(0, 9));
            if (r < 6)       stall = 3'b000;
            else if (r == 6) stall = 3'b001;
            else if (r == 7) stall = 3'b011;
            else             stall = 3'b111;
            flush = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst   = 1'b0;
        flush = 1'b0;
        stall = 3'b000;
        req(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
